// File: rtl/usr_xfer_ctrl.sv
// Transfer sequencer for a universal shift register: load, shift req_len times, stream the serial bit.
// Optional feature: ROTATE_SHIFT_EN adds req_rot (the outgoing bit is fed back into the vacated end).
//
// state | meaning
// IDLE  | waiting for a request, mode 00
// LOAD  | parallel load of captured word, mode 11
// SHIFT | shifting count more times, stall freezes
// DONE  | one-cycle completion pulse
module usr_xfer_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_len,
  input  logic [WIDTH-1:0] req_data,
`ifdef ROTATE_SHIFT_EN
  input  logic             req_rot,
`endif
  input  logic             stall,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             usr_s1,
  output logic             usr_s0,
  output logic [WIDTH-1:0] usr_data_in,
  output logic             usr_msb_in,
  output logic             usr_lsb_in,
  input  logic             usr_msb_out,
  input  logic             usr_lsb_out
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_q;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic             rot_q;
  logic [CNT_W-1:0] len_clamped;
  logic             rot_req;
  logic             fill_bit;

  assign len_clamped = (req_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : req_len;

`ifdef ROTATE_SHIFT_EN
  assign rot_req = req_rot;
`else
  assign rot_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      len_q  <= '0;
      data_q <= '0;
      dir_q  <= 1'b0;
      rot_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dir_q  <= req_dir;
            len_q  <= len_clamped;
            data_q <= req_data;
            rot_q  <= rot_req;
            state  <= LOAD;
          end
        end
        LOAD: begin
          count <= len_q;
          state <= (len_q == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          if (!stall) begin
            count <= count - 1'b1;
            if (count == CNT_W'(1)) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Rotation feeds the bit leaving the register back into the opposite end.
  assign fill_bit = rot_q ? (dir_q ? usr_msb_out : usr_lsb_out) : ser_in;

  always_comb begin
    req_ready   = (state == IDLE);
    busy        = (state != IDLE);
    done        = (state == DONE);
    ser_valid   = 1'b0;
    ser_out     = 1'b0;
    usr_s1      = 1'b0;
    usr_s0      = 1'b0;
    usr_data_in = data_q;
    usr_msb_in  = 1'b0;
    usr_lsb_in  = 1'b0;
    case (state)
      LOAD: begin
        usr_s1 = 1'b1;
        usr_s0 = 1'b1;
      end
      SHIFT: begin
        usr_msb_in = dir_q ? 1'b0 : fill_bit;
        usr_lsb_in = dir_q ? fill_bit : 1'b0;
        if (!stall) begin
          ser_valid = 1'b1;
          ser_out   = dir_q ? usr_msb_out : usr_lsb_out;
          usr_s1    = dir_q;
          usr_s0    = !dir_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usr_xfer_ctrl.sv
// Self-checking bench for usr_xfer_ctrl with a behavioural universal shift register attached.
module tb_usr_xfer_ctrl;
  localparam int W = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_dir = 1'b0;
  logic [CW-1:0] req_len = '0;
  logic [W-1:0]  req_data = '0;
  logic          req_rot = 1'b0;
  logic          stall = 1'b0;
  logic          ser_in = 1'b0;
  logic          ser_out, ser_valid, busy, done, usr_s1, usr_s0;
  logic [W-1:0]  usr_data_in;
  logic          usr_msb_in, usr_lsb_in;
  logic [W-1:0]  ureg = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  usr_xfer_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_len(req_len), .req_data(req_data),
`ifdef ROTATE_SHIFT_EN
    .req_rot(req_rot),
`endif
    .stall(stall), .ser_in(ser_in), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .done(done), .usr_s1(usr_s1), .usr_s0(usr_s0),
    .usr_data_in(usr_data_in), .usr_msb_in(usr_msb_in), .usr_lsb_in(usr_lsb_in),
    .usr_msb_out(ureg[W-1]), .usr_lsb_out(ureg[0])
  );

  // Universal shift register: 00 hold, 01 right, 10 left, 11 load.
  always @(posedge clk) begin
    case ({usr_s1, usr_s0})
      2'b01: ureg <= {usr_msb_in, ureg[W-1:1]};
      2'b10: ureg <= {ureg[W-2:0], usr_lsb_in};
      2'b11: ureg <= usr_data_in;
      default: ;
    endcase
  end

  typedef struct {
    logic [W-1:0]  data;
    logic          dir;
    logic [CW-1:0] len;
    logic          sin;
    logic          rot;
    logic [31:0]   mask;  // bit c: stall in c-th cycle after LOAD; bit 31: stall during LOAD
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_flags"},
        {23'd0, req_ready, busy, done, ser_valid, ser_out, usr_s1, usr_s0, usr_msb_in, usr_lsb_in},
        32'h100);
    chk({nm, "_data_in"}, {28'd0, usr_data_in}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int L, shifts, rot_eff, fill, fin;
    bit got_ready, finished;
    L = (v.len > W) ? W : int'(v.len);
`ifdef ROTATE_SHIFT_EN
    rot_eff = int'(v.rot);
`else
    rot_eff = 0;
`endif
    fill = v.sin ? ((1 << L) - 1) : 0;
    if (v.dir == 1'b0)
      fin = rot_eff ? (((v.data >> L) | (v.data << (W - L))) & 15)
                    : ((v.data >> L) | (fill << (W - L))) & 15;
    else
      fin = rot_eff ? (((v.data << L) | (v.data >> (W - L))) & 15)
                    : (((v.data << L) & 15) | fill);

    got_ready = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready) begin got_ready = 1; break; end
    end
    if (!got_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1; req_data = v.data; req_dir = v.dir; req_len = v.len;
    req_rot = v.rot; ser_in = v.sin; stall = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_data = W'($urandom); req_dir = ~v.dir; stall = v.mask[31];
    #1;
    chk("load_mode", {30'd0, usr_s1, usr_s0}, 32'd3);
    chk("load_data", {28'd0, usr_data_in}, {28'd0, v.data});
    chk("load_busy", {30'd0, busy, req_ready}, 32'd2);
    chk("load_ser_valid", {31'd0, ser_valid}, 32'd0);

    shifts = 0;
    finished = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      stall = (c < 31) ? v.mask[c] : 1'b0;
      req_valid = 1'(($urandom & 1));  // must be ignored while busy
      req_data = W'($urandom);
      #1;
      if (shifts == L) begin
        chk("done_pulse", {30'd0, done, busy}, 32'd3);
        chk("done_mode", {30'd0, usr_s1, usr_s0}, 32'd0);
        chk("final_reg", {28'd0, ureg}, fin);
        req_valid = 1'b0;
        finished = 1;
        break;
      end
      chk("shift_done_low", {31'd0, done}, 32'd0);
      if (stall) begin
        chk("stall_mode", {29'd0, ser_valid, usr_s1, usr_s0}, 32'd0);
      end else begin
        chk("shift_mode", {29'd0, ser_valid, usr_s1, usr_s0}, v.dir ? 32'd6 : 32'd5);
        chk("ser_out", {31'd0, ser_out},
            {31'd0, v.dir ? v.data[W-1-shifts] : v.data[shifts]});
        shifts++;
      end
    end
    if (!finished) chk("xfer_timeout", 0, 1);
    stall = 1'b0;
    @(negedge clk);
    #1;
    chk("back_idle", {30'd0, req_ready, busy}, 32'd2);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{4'b1011, 1'b0, 3'd3, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{4'b1011, 1'b1, 3'd4, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{4'b0110, 1'b0, 3'd0, 1'b1, 1'b0, 32'h8000_0000});
    tbl.push_back('{4'b1100, 1'b1, 3'd7, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{4'b1010, 1'b0, 3'd4, 1'b1, 1'b0, 32'h0000_0006});
    tbl.push_back('{4'b0101, 1'b1, 3'd2, 1'b0, 1'b0, 32'h8000_0001});
    tbl.push_back('{4'b1001, 1'b0, 3'd4, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{4'b1001, 1'b1, 3'd5, 1'b1, 1'b1, 32'h0000_0002});

    #1;
    chk_reset_outputs("reset_start");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_reset_outputs("after_release");

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset while idle, after a transfer left captured data non-zero.
    @(negedge clk);
    rst = 1'b0; #1;
    chk_reset_outputs("idle_reset");
    @(negedge clk);
    rst = 1'b1; #1;
    chk_reset_outputs("idle_reset_release");

    for (int r = 0; r < 40; r++) begin
      vec_t v;
      v.data = W'($urandom);
      v.dir  = 1'($urandom & 1);
      v.len  = CW'($urandom);
      v.sin  = 1'($urandom & 1);
      v.rot  = 1'($urandom & 1);
      v.mask = $urandom & $urandom & $urandom;
      run_vec(v);
    end

    // Reset in the middle of SHIFT: abort, no done afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_data = 4'b1110; req_dir = 1'b0; req_len = 3'd4; ser_in = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_abort_shifting", {30'd0, busy, ser_valid}, 32'd3);
    rst = 1'b0; #1;
    chk_reset_outputs("shift_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk("abort_no_done", {30'd0, done, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
